// File: rtl/oam_dma_if.sv
// Signal bundle between the OAM DMA sequencer and its CPU register, source-bus and OAM neighbours.
// master = the DMA controller, slave = the surrounding system (CPU decode, arbiter, memories).
interface oam_dma_if;
  // CPU register port ($FF46)
  logic        cpu_sel;
  logic        cpu_wr;
  logic [7:0]  cpu_di;
  logic [7:0]  cpu_do;
  // Source bus: bus_req/bus_gnt ownership handshake, dma_data returns one cycle after dma_rd
  logic        bus_req;
  logic        bus_gnt;
  logic        dma_rd;
  logic [15:0] dma_addr;
  logic [7:0]  dma_data;
  // OAM write port
  logic        oam_wr;
  logic [7:0]  oam_addr;
  logic [7:0]  oam_data;
  // Status
  logic        active;
  logic        done;
  logic [2:0]  dbg_state;

  modport master (
    input  cpu_sel, cpu_wr, cpu_di, bus_gnt, dma_data,
    output cpu_do, bus_req, dma_rd, dma_addr, oam_wr, oam_addr, oam_data,
           active, done, dbg_state
  );

  modport slave (
    output cpu_sel, cpu_wr, cpu_di, bus_gnt, dma_data,
    input  cpu_do, bus_req, dma_rd, dma_addr, oam_wr, oam_addr, oam_data,
           active, done, dbg_state
  );
endinterface

// File: rtl/oam_dma_ctrl.sv
// $FF46 OAM DMA sequencer: copies LEN bytes from page {src,8'h00} into OAM, one byte per slot.
// Optional build macro OAM_DMA_SRC_MIRROR_EN folds echo-RAM source pages $E0..$FF down by $20.
module oam_dma_ctrl #(
  parameter int LEN         = 160,
  parameter int START_DLY   = 4,
  parameter int SLOT_CYCLES = 4
) (
  input  logic      clk,
  input  logic      reset_n,
  oam_dma_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_REQ   = 3'd2,
    S_READ  = 3'd3,
    S_WRITE = 3'd4,
    S_PACE  = 3'd5
  } state_e;

  localparam logic [7:0] LAST_IDX = 8'(LEN - 1);
  localparam logic [7:0] DLY_LAST = 8'(START_DLY - 1);
  // READ and WRITE take the first two slot cycles; the slot's closing REQ cycle comes after PACE
  localparam logic [7:0] PACE_END = 8'(SLOT_CYCLES - 2);

  state_e      state_q;
  logic [7:0]  src_q;
  logic [7:0]  cpu_do_q;
  logic [7:0]  idx_q;
  logic [7:0]  dly_q;
  logic [7:0]  slot_q;
  logic [15:0] dma_addr_q;
  logic [7:0]  oam_addr_q;
  logic [7:0]  oam_data_q;
  logic        bus_req_q;
  logic        dma_rd_q;
  logic        oam_wr_q;
  logic        active_q;
  logic        done_q;

  logic        cpu_write;
  logic        last_byte;
  logic        start_over;
  logic        slot_over;
  logic [7:0]  rd_page;

  assign cpu_write  = bus.cpu_sel & bus.cpu_wr;
  assign last_byte  = (idx_q == LAST_IDX);
  assign start_over = (dly_q == DLY_LAST);
  assign slot_over  = (slot_q >= PACE_END);

`ifdef OAM_DMA_SRC_MIRROR_EN
  assign rd_page = (src_q >= 8'hE0) ? (src_q - 8'h20) : src_q;
`else
  assign rd_page = src_q;
`endif

  // Handshake: bus_req rises on entering REQ and is held until the transfer ends or restarts;
  // a byte is launched only on a cycle where bus_gnt is sampled high while in REQ, and once
  // launched the byte completes regardless of later grant changes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      src_q      <= 8'h00;
      cpu_do_q   <= 8'h00;
      idx_q      <= 8'h00;
      dly_q      <= 8'h00;
      slot_q     <= 8'h00;
      dma_addr_q <= 16'h0000;
      oam_addr_q <= 8'h00;
      oam_data_q <= 8'h00;
      bus_req_q  <= 1'b0;
      dma_rd_q   <= 1'b0;
      oam_wr_q   <= 1'b0;
      active_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      dma_rd_q <= 1'b0;
      oam_wr_q <= 1'b0;
      done_q   <= 1'b0;

      if (cpu_write) begin
        // A register write restarts from byte 0 in any state, including the final WRITE
        src_q     <= bus.cpu_di;
        cpu_do_q  <= bus.cpu_di;
        idx_q     <= 8'h00;
        dly_q     <= 8'h00;
        slot_q    <= 8'h00;
        bus_req_q <= 1'b0;
        active_q  <= 1'b1;
        state_q   <= S_START;
      end else begin
        case (state_q)
          S_IDLE: begin
            active_q  <= 1'b0;
            bus_req_q <= 1'b0;
          end

          S_START: begin
            if (start_over) begin
              bus_req_q <= 1'b1;
              state_q   <= S_REQ;
            end else begin
              dly_q <= dly_q + 8'd1;
            end
          end

          S_REQ: begin
            if (bus.bus_gnt) begin
              dma_rd_q   <= 1'b1;
              dma_addr_q <= {rd_page, idx_q};
              slot_q     <= 8'h00;
              state_q    <= S_READ;
            end
          end

          S_READ: begin
            slot_q  <= slot_q + 8'd1;
            state_q <= S_WRITE;
          end

          S_WRITE: begin
            // Sync source RAM: the byte requested in READ is on dma_data during this cycle
            oam_data_q <= bus.dma_data;
            oam_addr_q <= idx_q;
            oam_wr_q   <= 1'b1;
            slot_q     <= slot_q + 8'd1;
            state_q    <= S_PACE;
          end

          S_PACE: begin
            if (slot_over) begin
              if (last_byte) begin
                done_q    <= 1'b1;
                active_q  <= 1'b0;
                bus_req_q <= 1'b0;
                state_q   <= S_IDLE;
              end else begin
                idx_q   <= idx_q + 8'd1;
                state_q <= S_REQ;
              end
            end else begin
              slot_q <= slot_q + 8'd1;
            end
          end

          default: begin
            active_q  <= 1'b0;
            bus_req_q <= 1'b0;
            state_q   <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.cpu_do    = cpu_do_q;
  assign bus.bus_req   = bus_req_q;
  assign bus.dma_rd    = dma_rd_q;
  assign bus.dma_addr  = dma_addr_q;
  assign bus.oam_wr    = oam_wr_q;
  assign bus.oam_addr  = oam_addr_q;
  assign bus.oam_data  = oam_data_q;
  assign bus.active    = active_q;
  assign bus.done      = done_q;
  assign bus.dbg_state = state_q;

endmodule
